game_ctrl: RTL and testbench
============================

# game_ctrl

Turn-sequencing controller that sits directly upstream of the board store. It accepts player key presses, issues one-cycle `player_move`/`computer_move` strobes with cell addresses, and picks the computer's cell by a sequential scan of `board_data`. It also checks the board's `illegal_move`, `win` and `draw` responses and latches the game result.

## Interface
Parameters:
- `FIRST_MOVE`, default 0: who moves first after `start`; 0 = player, 1 = computer.
- `SETTLE`, default 2: cycles waited after a move strobe before sampling `win`/`draw`. Minimum 2.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a game; honoured only in IDLE.
- `key_valid`  in  1  player key press valid.
- `key_addr`  in  4  player cell index, 0..8, row-major (row = addr/3, col = addr%3).
- `key_ready`  out  1  high only in P_WAIT.
- `board_data`  in  18  cell n at bits [2n+1:2n]; 00 empty, 01 player, 10 computer.
- `illegal_move`  in  1  board response, valid one cycle after a move strobe.
- `win`  in  1  board win flag.
- `draw`  in  1  board draw flag.
- `winner`  in  2  board winner code; 01 player, 10 computer.
- `player_move`  out  1  one-cycle strobe.
- `player_adderss`  out  4  cell for `player_move`; held until the next accepted key.
- `computer_move`  out  1  one-cycle strobe.
- `computer_adderss`  out  4  cell for `computer_move`; held until the next scan.
- `bad_key`  out  1  one-cycle pulse when a key is rejected (addr > 8 or illegal).
- `game_over`  out  1  level; high in OVER.
- `result`  out  2  00 none, 01 player, 10 computer, 11 draw.

## Operation
- Reset values: all strobes 0; `key_ready` 0; both addresses 0; `game_over` 0; `result` 00; state IDLE.
- States: IDLE, P_WAIT, P_ISSUE, P_CHECK, C_SCAN, C_ISSUE, C_CHECK, OVER.
- **IDLE** on `start`:
  - to P_WAIT if `FIRST_MOVE` = 0.
  - to C_SCAN if `FIRST_MOVE` = 1.
- **P_WAIT**, on `key_valid` (handshake `key_valid && key_ready`):
  - If `key_addr` > 8: pulse `bad_key`, stay in P_WAIT.
  - Otherwise: latch `player_adderss`, go to P_ISSUE.
- **P_ISSUE**: `player_move` = 1 for exactly this cycle, then go to P_CHECK.
- **P_CHECK** lasts `SETTLE` cycles.
  - On the first cycle, sample `illegal_move`. If set: pulse `bad_key` and return to P_WAIT immediately.
  - On the last cycle, evaluate the end condition (see below).
  - If the game continues, go to C_SCAN.
- **C_SCAN** lasts exactly 9 cycles, with index i = 0..8, one cell per cycle. Track three candidates:
  - first empty cell that completes a computer line (WIN);
  - first empty cell that completes a player line (BLOCK);
  - first empty cell overall (ANY).
- **C_SCAN** pick, in priority order: WIN, then BLOCK, then cell 4 if empty, then ANY. Latch the pick into `computer_adderss`, then go to C_ISSUE.
  - If no empty cell is found: go to OVER with `result` = 11.
- **C_ISSUE**: `computer_move` = 1 for one cycle, then go to C_CHECK.
- **C_CHECK**: same as P_CHECK, except:
  - `illegal_move` here is an internal fault: go to OVER with `result` = 00.
  - If the game continues, go to P_WAIT.
- **End condition**, evaluated on the last check cycle:
  - `win`: `result` = `winner`.
  - Otherwise, `draw` or all 9 cells non-empty: `result` = 11.
  - When either applies, set `game_over` = 1 and go to OVER.
- **OVER** is sticky; only `rstn` leaves it. `start` is ignored.
- The 8 lines are the 3 rows, 3 columns and 2 diagonals. A cell "completes" a line when the other two cells of that line hold the same owner.

## Timing
- Key accepted at edge t. Then `player_move` is high in cycle t+1, and `illegal_move` is sampled in cycle t+2.
- Player turn, accept to C_SCAN entry: 2 + `SETTLE` cycles.
- Computer turn: 9 scan + 1 issue + `SETTLE` cycles, i.e. 12 cycles at default.
- `player_move` and `computer_move` are never high in the same cycle.
- `key_valid` in any state other than P_WAIT is ignored; there is no buffering.
- `rstn` asserted mid-game: state returns to IDLE immediately and outputs take reset values, with no strobe glitch.

## Structure
- Shared package holds:
  - cell codes EMPTY/PLAYER/COMPUTER;
  - `result` codes;
  - the 8-entry line table (three cell indices per line).
- The board store includes the same package.
- Sub-module `move_picker`: holds the C_SCAN index counter, the WIN/BLOCK/ANY candidate registers, and a `done` output.

## Test plan
- **Reset**, then `start` with `FIRST_MOVE` = 0 → `key_ready` = 1; all strobes 0; `result` = 00.
- **Key 4 accepted** → `player_move` high one cycle with `player_adderss` = 4; 12 cycles later `computer_move` pulses with cell 0 (first empty; center taken).
- **Occupied cell**: key 4 again after the board has cell 4 = 01 → `bad_key` pulse, state back to P_WAIT, no `computer_move`.
- **Out of range**: `key_addr` = 9, then 15 → `bad_key` each, no strobe.
- **Block**: board player at cells 0 and 1, cell 2 empty → computer picks 2. Win-over-block: computer at 3 and 4, player at 0 and 1 → computer picks 5.
- **End of game**: `win` = 1 with `winner` = 01 after the player move → `game_over` = 1, `result` = 01. A further `start`/`key_valid` gives no change; `rstn` low clears everything.

Source files
------------

// File: rtl/game_ctrl_pkg.sv
// Shared tic-tac-toe definitions: cell codes, result codes, FSM states, line table and board helpers.
// Pure declarations and functions; no latency, no flow control.
package game_ctrl_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,
    CELL_PLAYER   = 2'b01,
    CELL_COMPUTER = 2'b10
  } cell_e;

  localparam logic [1:0] RES_NONE     = 2'b00;
  localparam logic [1:0] RES_PLAYER   = 2'b01;
  localparam logic [1:0] RES_COMPUTER = 2'b10;
  localparam logic [1:0] RES_DRAW     = 2'b11;

  typedef enum logic [2:0] {
    IDLE, P_WAIT, P_ISSUE, P_CHECK, C_SCAN, C_ISSUE, C_CHECK, OVER
  } state_e;

  // Rows, columns, then the two diagonals.
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction

  // True when cell i lies on a line whose other two cells both belong to own.
  function automatic logic completes(input logic [17:0] b, input logic [3:0] i,
                                     input logic [1:0] own);
    logic hit;
    hit = 1'b0;
    for (int l = 0; l < 8; l++) begin
      logic on_line;
      int   n;
      on_line = 1'b0;
      n       = 0;
      for (int k = 0; k < 3; k++) begin
        if (LINES[l][k] == i) on_line = 1'b1;
        else if (cell_at(b, LINES[l][k]) == own) n++;
      end
      if (on_line && n == 2) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic board_full(input logic [17:0] b);
    logic full;
    full = 1'b1;
    for (int n = 0; n < 9; n++) begin
      if (cell_at(b, 4'(n)) == CELL_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/game_ctrl_move_picker.sv
// Scans the board one cell per cycle while scan is high; done and pick are valid in the 9th cycle.
// No backpressure: the caller holds scan for exactly the 9 scan cycles.
module move_picker
  import game_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        scan,
  input  logic [17:0] board_data,
  output logic        done,
  output logic        found,
  output logic [3:0]  pick
);

  logic [3:0] idx_q, idx_d;
  logic       win_vld_q, win_vld_d, blk_vld_q, blk_vld_d, any_vld_q, any_vld_d;
  logic [3:0] win_idx_q, win_idx_d, blk_idx_q, blk_idx_d, any_idx_q, any_idx_d;
  logic       ctr_q, ctr_d;

  always_comb begin
    idx_d     = 4'd0;
    win_vld_d = 1'b0;
    win_idx_d = 4'd0;
    blk_vld_d = 1'b0;
    blk_idx_d = 4'd0;
    any_vld_d = 1'b0;
    any_idx_d = 4'd0;
    ctr_d     = 1'b0;
    if (scan && idx_q <= 4'd8) begin
      idx_d     = idx_q + 4'd1;
      win_vld_d = win_vld_q;
      win_idx_d = win_idx_q;
      blk_vld_d = blk_vld_q;
      blk_idx_d = blk_idx_q;
      any_vld_d = any_vld_q;
      any_idx_d = any_idx_q;
      ctr_d     = ctr_q;
      if (cell_at(board_data, idx_q) == CELL_EMPTY) begin
        if (!win_vld_q && completes(board_data, idx_q, CELL_COMPUTER)) begin
          win_vld_d = 1'b1;
          win_idx_d = idx_q;
        end
        if (!blk_vld_q && completes(board_data, idx_q, CELL_PLAYER)) begin
          blk_vld_d = 1'b1;
          blk_idx_d = idx_q;
        end
        if (!any_vld_q) begin
          any_vld_d = 1'b1;
          any_idx_d = idx_q;
        end
        if (idx_q == 4'd4) ctr_d = 1'b1;
      end
    end
  end

  // Pick looks at the _d values so the last cell counts in the done cycle.
  assign done  = scan && (idx_q == 4'd8);
  assign found = any_vld_d;
  assign pick  = win_vld_d ? win_idx_d :
                 blk_vld_d ? blk_idx_d :
                 ctr_d     ? 4'd4      : any_idx_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q     <= 4'd0;
      win_vld_q <= 1'b0;
      win_idx_q <= 4'd0;
      blk_vld_q <= 1'b0;
      blk_idx_q <= 4'd0;
      any_vld_q <= 1'b0;
      any_idx_q <= 4'd0;
      ctr_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      win_vld_q <= win_vld_d;
      win_idx_q <= win_idx_d;
      blk_vld_q <= blk_vld_d;
      blk_idx_q <= blk_idx_d;
      any_vld_q <= any_vld_d;
      any_idx_q <= any_idx_d;
      ctr_q     <= ctr_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Turn sequencer: player key -> strobe -> check, then 9-cycle computer scan -> strobe -> check.
// Keys are taken only while key_ready; anything else is dropped, never buffered.
module game_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int FIRST_MOVE = 0,
  parameter int SETTLE     = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_addr,
  output logic        key_ready,
  input  logic [17:0] board_data,
  input  logic        illegal_move,
  input  logic        win,
  input  logic        draw,
  input  logic [1:0]  winner,
  output logic        player_move,
  output logic [3:0]  player_adderss,
  output logic        computer_move,
  output logic [3:0]  computer_adderss,
  output logic        bad_key,
  output logic        game_over,
  output logic [1:0]  result
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] padr_q, padr_d, cadr_q, cadr_d;
  logic [1:0] result_q, result_d;
  logic       scan_done, scan_found;
  logic [3:0] scan_pick;
  logic       last, ended;
  logic [1:0] end_res;

  move_picker u_picker (
    .clk        (clk),
    .rstn       (rstn),
    .scan       (state_q == C_SCAN),
    .board_data (board_data),
    .done       (scan_done),
    .found      (scan_found),
    .pick       (scan_pick)
  );

  assign last    = (cnt_q == 8'(SETTLE - 1));
  assign ended   = win || draw || board_full(board_data);
  assign end_res = win ? winner : RES_DRAW;

  always_comb begin
    state_d  = state_q;
    cnt_d    = 8'd0;
    padr_d   = padr_q;
    cadr_d   = cadr_q;
    result_d = result_q;
    bad_key  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = (FIRST_MOVE != 0) ? C_SCAN : P_WAIT;
      P_WAIT: begin
        if (key_valid) begin
          if (key_addr > 4'd8) begin
            bad_key = 1'b1;
          end else begin
            padr_d  = key_addr;
            state_d = P_ISSUE;
          end
        end
      end
      P_ISSUE: state_d = P_CHECK;
      P_CHECK: begin
        if (cnt_q == 8'd0 && illegal_move) begin
          bad_key = 1'b1;
          state_d = P_WAIT;
        end else if (last) begin
          if (ended) begin
            result_d = end_res;
            state_d  = OVER;
          end else begin
            state_d  = C_SCAN;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      C_SCAN: begin
        if (scan_done) begin
          if (scan_found) begin
            cadr_d  = scan_pick;
            state_d = C_ISSUE;
          end else begin
            result_d = RES_DRAW;
            state_d  = OVER;
          end
        end
      end
      C_ISSUE: state_d = C_CHECK;
      C_CHECK: begin
        // The computer only ever picks empty cells, so a rejection means the board is inconsistent.
        if (cnt_q == 8'd0 && illegal_move) begin
          result_d = RES_NONE;
          state_d  = OVER;
        end else if (last) begin
          if (ended) begin
            result_d = end_res;
            state_d  = OVER;
          end else begin
            state_d  = P_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  assign key_ready        = (state_q == P_WAIT);
  assign player_move      = (state_q == P_ISSUE);
  assign computer_move    = (state_q == C_ISSUE);
  assign game_over        = (state_q == OVER);
  assign player_adderss   = padr_q;
  assign computer_adderss = cadr_q;
  assign result           = result_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      padr_q   <= 4'd0;
      cadr_q   <= 4'd0;
      result_q <= RES_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      padr_q   <= padr_d;
      cadr_q   <= cadr_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: vector table of computer picks plus hand sequences for rejects and game end.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rstn, start, key_valid, illegal_move, win, draw;
  logic [3:0]  key_addr;
  logic [17:0] board_data;
  logic [1:0]  winner;
  logic        key_ready, player_move, computer_move, bad_key, game_over;
  logic [3:0]  player_adderss, computer_adderss;
  logic [1:0]  result;

  always #5 clk = ~clk;

  game_ctrl #(.FIRST_MOVE(0), .SETTLE(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .key_valid(key_valid), .key_addr(key_addr),
    .key_ready(key_ready), .board_data(board_data), .illegal_move(illegal_move),
    .win(win), .draw(draw), .winner(winner), .player_move(player_move),
    .player_adderss(player_adderss), .computer_move(computer_move),
    .computer_adderss(computer_adderss), .bad_key(bad_key), .game_over(game_over),
    .result(result)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] K_PM = 2'd0, K_CM = 2'd1, K_BK = 2'd2;
  typedef struct packed { logic [1:0] kind; logic [3:0] addr; } ev_t;
  ev_t sb[$];

  typedef struct {
    logic [3:0] key;
    logic [8:0] pl;
    logic [8:0] cp;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [3:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic got(input logic [1:0] kind, input logic [3:0] addr);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_strobe: got kind %0d addr %0d expected none", kind, addr);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      if (kind != K_BK) chk("sb_addr", 32'(addr), 32'(e.addr));
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (player_move || computer_move || bad_key)
        chk("move_overlap", 32'(player_move & computer_move), 32'd0);
      if (player_move)   got(K_PM, player_adderss);
      if (computer_move) got(K_CM, computer_adderss);
      if (bad_key)       got(K_BK, 4'd0);
    end
  end

  function automatic logic [17:0] bd(input logic [8:0] p, input logic [8:0] c);
    logic [17:0] r;
    r = '0;
    for (int n = 0; n < 9; n++) r[2*n +: 2] = p[n] ? 2'b01 : (c[n] ? 2'b10 : 2'b00);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] a);
    key_valid = 1'b1;
    key_addr  = a;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_cm(output int n);
    n = 0;
    while (computer_move !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] oob [2];
    oob[0] = 4'd9;
    oob[1] = 4'd15;
    // key, player cells, computer cells, expected computer pick
    vecs[0] = '{4'd4, 9'b000010000, 9'b000000000, 4'd0};  // center taken -> first empty
    vecs[1] = '{4'd1, 9'b000000011, 9'b000000000, 4'd2};  // block row 0
    vecs[2] = '{4'd1, 9'b000000011, 9'b000011000, 4'd5};  // win beats block
    vecs[3] = '{4'd0, 9'b000000001, 9'b000000000, 4'd4};  // center beats first empty
    vecs[4] = '{4'd4, 9'b000010001, 9'b100000000, 4'd1};  // no threats, center taken
    vecs[5] = '{4'd7, 9'b011000110, 9'b000000000, 4'd0};  // two blocks, lowest wins

    rstn = 1'b0; start = 1'b0; key_valid = 1'b0; key_addr = 4'd0; illegal_move = 1'b0;
    win = 1'b0; draw = 1'b0; winner = 2'b00; board_data = '0;
    tick();
    tick();
    chk("rst_key_ready", 32'(key_ready), 32'd0);
    chk("rst_player_move", 32'(player_move), 32'd0);
    chk("rst_computer_move", 32'(computer_move), 32'd0);
    chk("rst_bad_key", 32'(bad_key), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_padr", 32'(player_adderss), 32'd0);
    chk("rst_cadr", 32'(computer_adderss), 32'd0);
    rstn = 1'b1;
    tick();
    chk("idle_key_ready", 32'(key_ready), 32'd0);
    do_start();
    chk("start_key_ready", 32'(key_ready), 32'd1);
    chk("start_result", 32'(result), 32'd0);

    foreach (oob[i]) begin
      expect_ev(K_BK, 4'd0);
      press(oob[i]);
      chk("oob_stay", 32'(key_ready), 32'd1);
      chk("oob_no_move", 32'(player_move), 32'd0);
    end

    for (int i = 0; i < 6; i++) begin
      board_data = bd(vecs[i].pl, vecs[i].cp);
      expect_ev(K_PM, vecs[i].key);
      expect_ev(K_CM, vecs[i].exp);
      press(vecs[i].key);
      chk("pm_addr", 32'(player_adderss), 32'(vecs[i].key));
      wait_cm(n);
      chk("cm_latency", 32'(n), 32'd12);
      chk("cm_addr", 32'(computer_adderss), 32'(vecs[i].exp));
      n = 0;
      while (key_ready !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("back_to_pwait", 32'(n), 32'd3);
    end

    // Occupied cell: board rejects the move one cycle after the strobe.
    board_data = bd(9'b000010000, 9'b0);
    expect_ev(K_PM, 4'd4);
    expect_ev(K_BK, 4'd0);
    press(4'd4);
    tick();
    illegal_move = 1'b1;
    tick();
    illegal_move = 1'b0;
    chk("illegal_back", 32'(key_ready), 32'd1);
    repeat (15) tick();
    chk("illegal_no_cm", 32'(sb.size()), 32'd0);

    // Player wins on the check after their move.
    board_data = bd(9'b000000011, 9'b0);
    expect_ev(K_PM, 4'd2);
    press(4'd2);
    win = 1'b1;
    winner = 2'b01;
    tick();
    tick();
    tick();
    win = 1'b0;
    winner = 2'b00;
    chk("pwin_game_over", 32'(game_over), 32'd1);
    chk("pwin_result", 32'(result), 32'd1);
    start = 1'b1;
    key_valid = 1'b1;
    key_addr = 4'd3;
    tick();
    tick();
    start = 1'b0;
    key_valid = 1'b0;
    chk("over_sticky", 32'(game_over), 32'd1);
    chk("over_result", 32'(result), 32'd1);
    chk("over_key_ready", 32'(key_ready), 32'd0);
    rstn = 1'b0;
    #1;
    chk("arst_game_over", 32'(game_over), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_padr", 32'(player_adderss), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Computer wins on its own check.
    do_start();
    board_data = bd(9'b000000001, 9'b0);
    expect_ev(K_PM, 4'd0);
    expect_ev(K_CM, 4'd4);
    press(4'd0);
    wait_cm(n);
    win = 1'b1;
    winner = 2'b10;
    tick();
    tick();
    tick();
    win = 1'b0;
    chk("cwin_game_over", 32'(game_over), 32'd1);
    chk("cwin_result", 32'(result), 32'd2);
    do_reset();

    // Draw flag from the board.
    do_start();
    board_data = bd(9'b000100000, 9'b0);
    expect_ev(K_PM, 4'd5);
    press(4'd5);
    draw = 1'b1;
    tick();
    tick();
    tick();
    draw = 1'b0;
    chk("draw_result", 32'(result), 32'd3);
    do_reset();

    // Full board with no flags also ends as a draw.
    do_start();
    board_data = bd(9'b011001110, 9'b100110001);
    expect_ev(K_PM, 4'd8);
    press(4'd8);
    tick();
    tick();
    tick();
    chk("full_game_over", 32'(game_over), 32'd1);
    chk("full_result", 32'(result), 32'd3);

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
